// File: rtl/parity_tx_ctrl_if.sv
// Handshake bundle for parity_tx_ctrl: word-in side and serial-out side.
// The slave modport is the transmitter's view and the master modport is the environment's view.
interface parity_tx_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_odd;
  logic              ser_valid;
  logic              ser_ready;
  logic              ser_bit;
  logic              ser_last;

  modport master (
    output in_valid, in_data, in_odd, ser_ready,
    input  in_ready, ser_valid, ser_bit, ser_last
  );

  modport slave (
    input  in_valid, in_data, in_odd, ser_ready,
    output in_ready, ser_valid, ser_bit, ser_last
  );
endinterface

// File: rtl/parity_tx_ctrl.sv
// Parity serializer. It accepts one DATA_W-bit word, sends it LSB first, and then sends
// one parity bit (even or odd, selected per word). It also counts completed frames.
module parity_tx_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  parity_tx_ctrl_if.slave      bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam int BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DATA = 2'b01,
    S_PAR  = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                acc_q,   acc_d;
  logic [BIT_W-1:0]    cnt_q,   cnt_d;
  logic                odd_q,   odd_d;
  logic [CNT_W-1:0]    frame_q, frame_d;

  logic in_ready_s;
  logic ser_valid_s;
  logic ser_bit_s;
  logic ser_last_s;
  logic busy_s;
  logic accept_s;
  logic xfer_s;

  // The parity bit is the running XOR of the data bits, inverted when the mode is odd.
  function automatic logic par_bit(input logic acc, input logic odd);
    return acc ^ odd;
  endfunction

  assign accept_s = bus.in_valid & in_ready_s;
  assign xfer_s   = ser_valid_s & bus.ser_ready;

  // State register. Reset wins over any accept or transfer on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= {DATA_W{1'b0}};
      acc_q   <= 1'b0;
      cnt_q   <= {BIT_W{1'b0}};
      odd_q   <= 1'b0;
      frame_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      odd_q   <= odd_d;
      frame_q <= frame_d;
    end
  end

  // Next-state logic. Without a handshake, every field keeps its value.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    odd_d   = odd_q;
    frame_d = frame_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_DATA;
          shift_d = bus.in_data;
          odd_d   = bus.in_odd;
          acc_d   = 1'b0;
          cnt_d   = {BIT_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (xfer_s) begin
          acc_d   = acc_q ^ shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + BIT_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = S_PAR;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PAR: begin
        if (xfer_s) begin
          state_d = S_IDLE;
          frame_d = frame_q + CNT_W'(1);
        end else begin
          state_d = S_PAR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode. The outputs depend only on registered state, so they hold steady while stalled.
  always_comb begin
    in_ready_s  = 1'b0;
    ser_valid_s = 1'b0;
    ser_bit_s   = 1'b0;
    ser_last_s  = 1'b0;
    busy_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready_s = 1'b1;
      end
      S_DATA: begin
        ser_valid_s = 1'b1;
        ser_bit_s   = shift_q[0];
        busy_s      = 1'b1;
      end
      S_PAR: begin
        ser_valid_s = 1'b1;
        ser_bit_s   = par_bit(acc_q, odd_q);
        ser_last_s  = 1'b1;
        busy_s      = 1'b1;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.ser_valid = ser_valid_s;
  assign bus.ser_bit   = ser_bit_s;
  assign bus.ser_last  = ser_last_s;
  assign busy          = busy_s;
  assign frame_cnt     = frame_q;

endmodule

// File: tb/tb_parity_tx_ctrl.sv
// Directed, table-driven bench for parity_tx_ctrl. It drives inputs and samples outputs on the falling clock edge.
// A 4-bit frame counter keeps the wrap-around case short.
module tb_parity_tx_ctrl;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic clk;
  logic rst;
  logic busy;
  logic [CNT_W-1:0] frame_cnt;

  int checks;
  int errors;
  logic [CNT_W-1:0] exp_cnt;

  parity_tx_ctrl_if #(.DATA_W(DATA_W)) bus_if ();

  parity_tx_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       odd;
    logic       exp_par;
    int         stall_idx;
    logic       inject;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Sends one frame with ser_ready high, except for an optional 5-cycle stall.
  // When inject is set, it offers a different word while the frame is busy.
  task automatic run_frame(input logic [7:0] d, input logic o, input logic exp_p,
                           input int stall_idx, input logic inject);
    int xfers;
    xfers = 0;
    @(negedge clk);
    chk("idle_in_ready", 32'(bus_if.in_ready), 32'd1);
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = d;
    bus_if.in_odd    = o;
    bus_if.ser_ready = 1'b1;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      chk("data_valid", 32'(bus_if.ser_valid), 32'd1);
      chk("data_last",  32'(bus_if.ser_last),  32'd0);
      chk("data_bit",   32'(bus_if.ser_bit),   32'(d[i]));
      chk("data_busy",  32'(busy),             32'd1);
      if (inject) begin
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 8'h3C;
        bus_if.in_odd   = ~o;
        chk("busy_in_ready", 32'(bus_if.in_ready), 32'd0);
      end
      if (i == stall_idx) begin
        bus_if.ser_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_valid", 32'(bus_if.ser_valid), 32'd1);
          chk("stall_bit",   32'(bus_if.ser_bit),   32'(d[i]));
          chk("stall_last",  32'(bus_if.ser_last),  32'd0);
          chk("stall_busy",  32'(busy),             32'd1);
        end
        bus_if.ser_ready = 1'b1;
      end
      if (bus_if.ser_valid === 1'b1) xfers++;
      @(negedge clk);
    end
    bus_if.in_valid = 1'b0;
    chk("par_valid", 32'(bus_if.ser_valid), 32'd1);
    chk("par_last",  32'(bus_if.ser_last),  32'd1);
    chk("par_bit",   32'(bus_if.ser_bit),   32'(exp_p));
    if (bus_if.ser_valid === 1'b1) xfers++;
    @(negedge clk);
    exp_cnt = exp_cnt + 1'b1;
    chk("end_in_ready",  32'(bus_if.in_ready),  32'd1);
    chk("end_busy",      32'(busy),             32'd0);
    chk("end_ser_valid", 32'(bus_if.ser_valid), 32'd0);
    chk("end_ser_bit",   32'(bus_if.ser_bit),   32'd0);
    chk("end_ser_last",  32'(bus_if.ser_last),  32'd0);
    chk("frame_cnt",     32'(frame_cnt),        32'(exp_cnt));
    chk("xfer_count",    32'(xfers),            32'(DATA_W + 1));
  endtask

  // Starts a frame and asserts reset while bit 4 is presented. A new word is offered on the
  // same edge, and reset must override it.
  task automatic reset_mid_frame(input logic [7:0] d);
    @(negedge clk);
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = d;
    bus_if.in_odd    = 1'b0;
    bus_if.ser_ready = 1'b1;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("pre_rst_bit", 32'(bus_if.ser_bit), 32'(d[i]));
      @(negedge clk);
    end
    chk("bit4_busy", 32'(busy), 32'd1);
    rst             = 1'b1;
    bus_if.in_valid = 1'b1;
    @(negedge clk);
    rst             = 1'b0;
    bus_if.in_valid = 1'b0;
    exp_cnt = '0;
    chk("rst_ser_valid", 32'(bus_if.ser_valid), 32'd0);
    chk("rst_in_ready",  32'(bus_if.in_ready),  32'd1);
    chk("rst_busy",      32'(busy),             32'd0);
    chk("rst_ser_bit",   32'(bus_if.ser_bit),   32'd0);
    chk("rst_ser_last",  32'(bus_if.ser_last),  32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt),        32'd0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = '0;
    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = 8'h00;
    bus_if.in_odd    = 1'b0;
    bus_if.ser_ready = 1'b0;

    vecs[0] = '{data: 8'hA5, odd: 1'b0, exp_par: 1'b0, stall_idx: -1, inject: 1'b0};
    vecs[1] = '{data: 8'hA5, odd: 1'b1, exp_par: 1'b1, stall_idx: -1, inject: 1'b0};
    vecs[2] = '{data: 8'h07, odd: 1'b0, exp_par: 1'b1, stall_idx: -1, inject: 1'b0};
    vecs[3] = '{data: 8'h00, odd: 1'b1, exp_par: 1'b1, stall_idx: -1, inject: 1'b0};
    vecs[4] = '{data: 8'hFF, odd: 1'b0, exp_par: 1'b0, stall_idx: 3,  inject: 1'b0};
    vecs[5] = '{data: 8'h01, odd: 1'b1, exp_par: 1'b0, stall_idx: -1, inject: 1'b1};
    vecs[6] = '{data: 8'h80, odd: 1'b0, exp_par: 1'b1, stall_idx: -1, inject: 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_in_ready",  32'(bus_if.in_ready),  32'd1);
    chk("reset_ser_valid", 32'(bus_if.ser_valid), 32'd0);
    chk("reset_ser_bit",   32'(bus_if.ser_bit),   32'd0);
    chk("reset_ser_last",  32'(bus_if.ser_last),  32'd0);
    chk("reset_busy",      32'(busy),             32'd0);
    chk("reset_frame_cnt", 32'(frame_cnt),        32'd0);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].data, vecs[v].odd, vecs[v].exp_par, vecs[v].stall_idx, vecs[v].inject);
    end

    reset_mid_frame(8'hA5);
    run_frame(8'hA5, 1'b0, 1'b0, -1, 1'b0);

    // Fill the counter to its maximum value, then complete one more frame so it wraps to zero.
    for (int f = 0; f < 14; f++) begin
      logic [7:0] fd;
      logic       fo;
      fd = 8'(f * 37 + 3);
      fo = f[0];
      run_frame(fd, fo, (^fd) ^ fo, -1, 1'b0);
    end
    chk("cnt_max", 32'(frame_cnt), 32'd15);
    run_frame(8'h07, 1'b0, 1'b1, -1, 1'b0);
    chk("cnt_wrap", 32'(frame_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
